// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: priority and handshake stage of an 8237A-style DMA core.
// Synchronises the asynchronous DREQ lines and merges them with the mask and software
// requests. Picks a winning channel with fixed or rotating priority, runs the HRQ/HLDA
// bus-hold handshake and drives DACK. The granted channel goes to timing control/datapath.
//
// Ports:
//   clk_i               core clock
//   rst_i               asynchronous active-high reset
//   dreq_i[3:0]         asynchronous channel requests (polarity per dreq_sense_low_i)
//   hlda_i              hold acknowledge from the CPU
//   mask_i[3:0]         channel mask (1 = masked); does not affect software requests
//   sw_req_i[3:0]       software request bits
//   dreq_sense_low_i    1 = DREQ active-low
//   dack_sense_high_i   1 = DACK active-high
//   rot_pri_i           1 = rotating priority, 0 = fixed (ch0 highest)
//   ctrl_disable_i      1 = no new requests accepted from idle
//   tc_done_i           1-cycle pulse: service of grant_ch_o complete
//   hrq_o               hold request to the CPU (registered)
//   dack_o[3:0]         one-hot acknowledge at the selected active level
//   grant_vld_o         a channel is granted and the bus is owned
//   grant_ch_o[1:0]     encoded granted channel, stable while grant_vld_o = 1
//   sw_req_clr_o[3:0]   1-cycle pulse clearing the serviced channel's software request

module dma_priority_arbiter #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [NCH-1:0] dreq_i,
    input  logic           hlda_i,
    input  logic [NCH-1:0] mask_i,
    input  logic [NCH-1:0] sw_req_i,
    input  logic           dreq_sense_low_i,
    input  logic           dack_sense_high_i,
    input  logic           rot_pri_i,
    input  logic           ctrl_disable_i,
    input  logic           tc_done_i,
    output logic           hrq_o,
    output logic [NCH-1:0] dack_o,
    output logic           grant_vld_o,
    output logic [1:0]     grant_ch_o,
    output logic [NCH-1:0] sw_req_clr_o
);

    typedef enum logic [1:0] {StIdle, StReq, StActive, StRelease} state_e;

    state_e         state_q;
    logic           hrq_q;
    logic [NCH-1:0] dack_q;
    logic           grant_vld_q;
    logic [1:0]     grant_ch_q;
    logic [NCH-1:0] sw_req_clr_q;
    logic [1:0]     ptr_q;          // highest-priority channel in rotating mode
    logic [NCH-1:0] sync_q [SYNC_STAGES];

    logic [NCH-1:0] dreq_s;
    logic [NCH-1:0] eff_req;
    logic [1:0]     start_ch;
    logic [1:0]     idx;
    logic           win_vld;
    logic [1:0]     win_ch;
    logic [NCH-1:0] win_oh;
    logic [NCH-1:0] grant_oh;

    // DREQ synchroniser chain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= dreq_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign dreq_s   = sync_q[SYNC_STAGES-1] ^ {NCH{dreq_sense_low_i}};
    assign eff_req  = (dreq_s & ~mask_i) | sw_req_i;
    assign start_ch = rot_pri_i ? ptr_q : 2'd0;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        win_vld = 1'b0;
        win_ch  = 2'd0;
        idx     = 2'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = start_ch + 2'(i);
            if (eff_req[idx]) begin
                win_vld = 1'b1;
                win_ch  = idx;
            end
        end
    end

    assign win_oh   = {{(NCH-1){1'b0}}, 1'b1} << win_ch;
    assign grant_oh = {{(NCH-1){1'b0}}, 1'b1} << grant_ch_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            hrq_q        <= 1'b0;
            dack_q       <= '0;
            grant_vld_q  <= 1'b0;
            grant_ch_q   <= 2'd0;
            sw_req_clr_q <= '0;
            ptr_q        <= 2'd0;
        end else begin
            sw_req_clr_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (win_vld && !ctrl_disable_i) begin
                        state_q <= StReq;
                        hrq_q   <= 1'b1;
                    end
                end
                StReq: begin
                    if (!win_vld) begin
                        state_q <= StIdle;
                        hrq_q   <= 1'b0;
                    end else if (hlda_i) begin
                        grant_ch_q  <= win_ch;
                        dack_q      <= win_oh;
                        grant_vld_q <= 1'b1;
                        state_q     <= StActive;
                    end
                end
                StActive: begin
                    // Completion takes precedence over a simultaneous HLDA drop.
                    if (tc_done_i) begin
                        dack_q       <= '0;
                        grant_vld_q  <= 1'b0;
                        hrq_q        <= 1'b0;
                        sw_req_clr_q <= grant_oh;
                        if (rot_pri_i) begin
                            ptr_q <= grant_ch_q + 2'd1;
                        end
                        state_q <= StRelease;
                    end else if (!hlda_i) begin
                        dack_q      <= '0;
                        grant_vld_q <= 1'b0;
                        hrq_q       <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                StRelease: begin
                    if (!hlda_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hrq_o        = hrq_q;
    assign dack_o       = dack_sense_high_i ? dack_q : ~dack_q;
    assign grant_vld_o  = grant_vld_q;
    assign grant_ch_o   = grant_ch_q;
    assign sw_req_clr_o = sw_req_clr_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter.
module tb_dma_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dreq, mask, sw_req;
    logic       hlda, sense_low, sense_high, rot_pri, ctrl_disable, tc_done;
    logic       hrq, grant_vld;
    logic [3:0] dack, sw_req_clr;
    logic [1:0] grant_ch;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dma_priority_arbiter #(.NCH(4), .SYNC_STAGES(2)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .dreq_i            (dreq),
        .hlda_i            (hlda),
        .mask_i            (mask),
        .sw_req_i          (sw_req),
        .dreq_sense_low_i  (sense_low),
        .dack_sense_high_i (sense_high),
        .rot_pri_i         (rot_pri),
        .ctrl_disable_i    (ctrl_disable),
        .tc_done_i         (tc_done),
        .hrq_o             (hrq),
        .dack_o            (dack),
        .grant_vld_o       (grant_vld),
        .grant_ch_o        (grant_ch),
        .sw_req_clr_o      (sw_req_clr)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_hrq();
        int k;
        k = 0;
        while (!hrq && k < 10) begin
            tick();
            k++;
        end
        check("hrq_wait", {7'd0, hrq}, 8'd1);
    endtask

    // Full service: grant on HLDA, hold, tc_done, release.
    task automatic serve(input string tag, input logic [1:0] ch, input logic [3:0] exp_dack,
                         input logic [3:0] exp_inactive, input logic [3:0] exp_clr);
        wait_hrq();
        hlda = 1'b1;
        tick();
        check({tag, "_vld"}, {7'd0, grant_vld}, 8'd1);
        check({tag, "_ch"}, {6'd0, grant_ch}, {6'd0, ch});
        check({tag, "_dack"}, {4'd0, dack}, {4'd0, exp_dack});
        tick();
        check({tag, "_ch_hold"}, {6'd0, grant_ch}, {6'd0, ch});
        tc_done = 1'b1;
        tick();
        tc_done = 1'b0;
        check({tag, "_vld_off"}, {7'd0, grant_vld}, 8'd0);
        check({tag, "_hrq_off"}, {7'd0, hrq}, 8'd0);
        check({tag, "_clr"}, {4'd0, sw_req_clr}, {4'd0, exp_clr});
        check({tag, "_dack_off"}, {4'd0, dack}, {4'd0, exp_inactive});
        hlda = 1'b0;
        tick();
        check({tag, "_clr_pulse"}, {4'd0, sw_req_clr}, 8'd0);
    endtask

    // Drop requests under full mask so no edge in the sync pipe can start a cycle.
    task automatic flush(input logic new_sense_low);
        mask      = 4'hF;
        dreq      = new_sense_low ? 4'hF : 4'h0;
        sense_low = new_sense_low;
        tick(4);
        mask = 4'h0;
        tick();
        check("flush_hrq", {7'd0, hrq}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; dreq = 4'h0; mask = 4'h0; sw_req = 4'h0; hlda = 1'b0;
        sense_low = 1'b0; sense_high = 1'b0; rot_pri = 1'b0; ctrl_disable = 1'b0;
        tc_done = 1'b0;
        tick(2);
        check("rst_hrq", {7'd0, hrq}, 8'd0);
        check("rst_dack", {4'd0, dack}, 8'h0F);
        check("rst_vld", {7'd0, grant_vld}, 8'd0);
        check("rst_ch", {6'd0, grant_ch}, 8'd0);
        check("rst_clr", {4'd0, sw_req_clr}, 8'd0);
        rst = 1'b0;
        tick();

        // 1: fixed priority and DREQ->HRQ latency
        dreq = 4'b1010;
        tick(2);
        check("t1_hrq_early", {7'd0, hrq}, 8'd0);
        tick();
        check("t1_hrq_rise", {7'd0, hrq}, 8'd1);
        serve("t1", 2'd1, 4'b1101, 4'hF, 4'b0010);
        flush(1'b0);

        // 2: rotating priority, ch1 and ch3 held, pointer wraps 3->0
        rot_pri = 1'b1;
        dreq    = 4'b1010;
        serve("t2a", 2'd1, 4'b1101, 4'hF, 4'b0010);
        serve("t2b", 2'd3, 4'b0111, 4'hF, 4'b1000);
        serve("t2c", 2'd1, 4'b1101, 4'hF, 4'b0010);
        flush(1'b0);

        // 3: full mask blocks DREQ; software request ignores mask
        mask = 4'hF;
        dreq = 4'hF;
        tick(5);
        check("t3_masked", {7'd0, hrq}, 8'd0);
        sw_req = 4'b0100;
        serve("t3", 2'd2, 4'b1011, 4'hF, 4'b0100);
        sw_req = 4'h0;
        flush(1'b0);

        // 4: active-low DREQ, active-high DACK
        flush(1'b1);
        sense_high = 1'b1;
        #1;
        check("t4_dack_idle", {4'd0, dack}, 8'h00);
        dreq = 4'b1110;
        serve("t4", 2'd0, 4'b0001, 4'h0, 4'b0001);
        flush(1'b0);
        sense_high = 1'b0;

        // 5: abort; pointer is ch1 after the ch0 service and must stay there
        dreq = 4'b0110;
        wait_hrq();
        hlda = 1'b1;
        tick();
        check("t5_ch", {6'd0, grant_ch}, 8'd1);
        hlda = 1'b0;
        tick();
        check("t5_abort_dack", {4'd0, dack}, 8'h0F);
        check("t5_abort_hrq", {7'd0, hrq}, 8'd0);
        check("t5_abort_vld", {7'd0, grant_vld}, 8'd0);
        check("t5_abort_clr", {4'd0, sw_req_clr}, 8'd0);
        serve("t5r", 2'd1, 4'b1101, 4'hF, 4'b0010);
        flush(1'b0);

        // 6: asynchronous reset in ACTIVE
        dreq = 4'b0001;
        wait_hrq();
        hlda = 1'b1;
        tick();
        check("t6_active", {7'd0, grant_vld}, 8'd1);
        #2;
        rst  = 1'b1;
        #1;
        check("t6_rst_hrq", {7'd0, hrq}, 8'd0);
        check("t6_rst_dack", {4'd0, dack}, 8'h0F);
        check("t6_rst_vld", {7'd0, grant_vld}, 8'd0);
        hlda = 1'b0;
        dreq = 4'h0;
        tick(2);
        rst = 1'b0;
        tick(5);
        check("t6_quiet", {7'd0, hrq}, 8'd0);
        dreq = 4'b0100;
        tick(3);
        check("t6_new_req", {7'd0, hrq}, 8'd1);
        serve("t6", 2'd2, 4'b1011, 4'hF, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
